alu_operand_fetch: RTL

ALU_OPERAND_FETCH -- requirements
Module: alu_operand_fetch

---
 rtl/alu_operand_fetch.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_operand_fetch.sv
// Operand fetch stage: register file, EX/WB hazard tracking and branch/JALR redirect.
// Optional macro ALU_OPERAND_FETCH_BYPASS_EN forwards the WB result instead of stalling on it.
module alu_operand_fetch #(
  parameter int DatapathWidth     = 64,
  parameter int AluOperationWidth = 5,
  parameter int NumRegs           = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          instr_valid_i,
  output logic                          instr_ready_o,
  input  logic [AluOperationWidth-1:0]  instr_op_i,
  input  logic [$clog2(NumRegs)-1:0]    instr_rs1_i,
  input  logic [$clog2(NumRegs)-1:0]    instr_rs2_i,
  input  logic [$clog2(NumRegs)-1:0]    instr_rd_i,
  input  logic [DatapathWidth-1:0]      instr_imm_i,
  input  logic [DatapathWidth-1:0]      instr_pc_i,
  output logic                          alu_valid_o,
  output logic [AluOperationWidth-1:0]  operation_o,
  output logic [DatapathWidth-1:0]      operand1_o,
  output logic [DatapathWidth-1:0]      operand2_o,
  output logic [DatapathWidth-1:0]      immediate_o,
  output logic [DatapathWidth-1:0]      pc_o,
  input  logic [DatapathWidth-1:0]      alu_result_i,
  input  logic                          alu_branch_taken_i,
  output logic                          redirect_valid_o,
  output logic [DatapathWidth-1:0]      redirect_pc_o
);

  localparam int RegIdxWidth = $clog2(NumRegs);
  typedef logic [AluOperationWidth-1:0] op_t;
  typedef logic [RegIdxWidth-1:0]       idx_t;

  function automatic logic op_writes(input op_t op);
    return (op <= op_t'(9)) || ((op >= op_t'(16)) && (op <= op_t'(24)));
  endfunction

  function automatic logic op_is_branch(input op_t op);
    return (op >= op_t'(10)) && (op <= op_t'(15));
  endfunction

  function automatic logic op_is_jalr(input op_t op);
    return op == op_t'(25);
  endfunction

  // Unassigned opcodes 26+ are treated like register-register ops for hazard purposes.
  function automatic logic op_uses_rs2(input op_t op);
    return (op <= op_t'(15)) || (op >= op_t'(26));
  endfunction

  logic                     ex_valid_reg, wb_valid_reg;
  logic                     ex_writes_reg, wb_writes_reg;
  logic                     ex_branch_reg, wb_branch_reg;
  logic                     ex_jalr_reg, wb_jalr_reg;
  idx_t                     ex_rd_reg, wb_rd_reg;
  op_t                      operation_reg;
  logic [DatapathWidth-1:0] operand1_reg, operand2_reg, immediate_reg, pc_reg;
  logic [DatapathWidth-1:0] rf_q [NumRegs];

  logic rs1_used, rs2_used, cand_writes;
  logic ex_hazard, wb_hit1, wb_hit2, ctrl_busy, wb_stall;
  logic bypass1, bypass2, accept;
  logic [DatapathWidth-1:0] rs1_data, rs2_data;

  assign cand_writes = op_writes(instr_op_i) && (instr_rd_i != '0);
  assign rs1_used    = instr_rs1_i != '0;
  assign rs2_used    = op_uses_rs2(instr_op_i) && (instr_rs2_i != '0);

  assign ex_hazard = ex_valid_reg && ex_writes_reg &&
                     ((rs1_used && (instr_rs1_i == ex_rd_reg)) ||
                      (rs2_used && (instr_rs2_i == ex_rd_reg)));
  assign wb_hit1   = wb_valid_reg && wb_writes_reg && rs1_used && (instr_rs1_i == wb_rd_reg);
  assign wb_hit2   = wb_valid_reg && wb_writes_reg && rs2_used && (instr_rs2_i == wb_rd_reg);
  assign ctrl_busy = (ex_valid_reg && (ex_branch_reg || ex_jalr_reg)) ||
                     (wb_valid_reg && (wb_branch_reg || wb_jalr_reg));

`ifdef ALU_OPERAND_FETCH_BYPASS_EN
  assign bypass1  = wb_hit1;
  assign bypass2  = wb_hit2;
  assign wb_stall = 1'b0;
`else
  assign bypass1  = 1'b0;
  assign bypass2  = 1'b0;
  assign wb_stall = wb_hit1 || wb_hit2;
`endif

  assign instr_ready_o = !rst_i && !ex_hazard && !ctrl_busy && !wb_stall;
  assign accept        = instr_valid_i && instr_ready_o;

  // Unused sources read as zero, which also gives operand2 = 0 for rs1-only ops.
  assign rs1_data = !rs1_used ? '0 : (bypass1 ? alu_result_i : rf_q[instr_rs1_i]);
  assign rs2_data = !rs2_used ? '0 : (bypass2 ? alu_result_i : rf_q[instr_rs2_i]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_reg  <= 1'b0;
      ex_writes_reg <= 1'b0;
      ex_branch_reg <= 1'b0;
      ex_jalr_reg   <= 1'b0;
      ex_rd_reg     <= '0;
      wb_valid_reg  <= 1'b0;
      wb_writes_reg <= 1'b0;
      wb_branch_reg <= 1'b0;
      wb_jalr_reg   <= 1'b0;
      wb_rd_reg     <= '0;
      operation_reg <= '0;
      operand1_reg  <= '0;
      operand2_reg  <= '0;
      immediate_reg <= '0;
      pc_reg        <= '0;
    end else begin
      ex_valid_reg <= accept;
      if (accept) begin
        ex_writes_reg <= cand_writes;
        ex_branch_reg <= op_is_branch(instr_op_i);
        ex_jalr_reg   <= op_is_jalr(instr_op_i);
        ex_rd_reg     <= instr_rd_i;
        operation_reg <= instr_op_i;
        operand1_reg  <= rs1_data;
        operand2_reg  <= rs2_data;
        immediate_reg <= instr_imm_i;
        pc_reg        <= instr_pc_i;
      end
      wb_valid_reg  <= ex_valid_reg;
      wb_writes_reg <= ex_writes_reg;
      wb_branch_reg <= ex_branch_reg;
      wb_jalr_reg   <= ex_jalr_reg;
      wb_rd_reg     <= ex_rd_reg;
    end
  end

  // Register 0 is hardwired; the rest are written at the end of WB.
  assign rf_q[0] = '0;
  genvar gi;
  generate
    for (gi = 1; gi < NumRegs; gi++) begin : g_reg
      logic [DatapathWidth-1:0] value_reg;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          value_reg <= '0;
        end else if (wb_valid_reg && wb_writes_reg && (wb_rd_reg == idx_t'(gi))) begin
          value_reg <= alu_result_i;
        end
      end
      assign rf_q[gi] = value_reg;
    end
  endgenerate

  assign alu_valid_o = ex_valid_reg;
  assign operation_o = operation_reg;
  assign operand1_o  = operand1_reg;
  assign operand2_o  = operand2_reg;
  assign immediate_o = immediate_reg;
  assign pc_o        = pc_reg;

  assign redirect_valid_o = !rst_i && wb_valid_reg &&
                            (wb_jalr_reg || (wb_branch_reg && alu_branch_taken_i));

  always_comb begin
    redirect_pc_o = '0;
    if (redirect_valid_o) begin
      redirect_pc_o = alu_result_i;
      if (wb_jalr_reg) redirect_pc_o[0] = 1'b0;
    end
  end

endmodule
